// File: rtl/alu_issue_scoreboard.sv
// ALU issue stage: register scoreboard with a one-entry issue register; optional SCOREBOARD_WB_BYPASS_EN.
// Latency 1 cycle decode->issue; decode stalls on hazard or when the issue register is held by !issue_ready.
module alu_issue_scoreboard (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [3:0]  alu_a_select,
    input  logic [3:0]  alu_b_select,
    input  logic [3:0]  alu_c_select,
    input  logic [3:0]  alu_d_select,
    input  logic [3:0]  alu_Y1_select,
    input  logic [3:0]  alu_Y2_select,
    input  logic [1:0]  alu_write,
    input  logic        invalid_instruction,
    input  logic [47:0] fields_in,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [3:0]  issue_a_select,
    output logic [3:0]  issue_b_select,
    output logic [3:0]  issue_c_select,
    output logic [3:0]  issue_d_select,
    output logic [3:0]  issue_Y1_select,
    output logic [3:0]  issue_Y2_select,
    output logic [1:0]  issue_write,
    output logic [47:0] issue_fields,
    input  logic        wb_valid,
    input  logic [3:0]  wb_Y1_select,
    input  logic [3:0]  wb_Y2_select,
    input  logic [1:0]  wb_write,
    output logic [15:0] pending,
    output logic        illegal_seen,
    output logic [15:0] stall_count
);

    logic        issue_valid_q, issue_valid_d;
    logic [3:0]  a_q, b_q, c_q, d_q, y1_q, y2_q;
    logic [1:0]  write_q;
    logic [47:0] fields_q;
    logic [15:0] pending_q, pending_d;
    logic        illegal_q, illegal_d;
    logic [15:0] stall_q, stall_d;

    logic [15:0] wb_clr, acc_set, pending_eff;
    logic        hazard, accept, issue_load;

    always_comb begin
        wb_clr = '0;
        if (wb_valid) begin
            if (wb_write[0]) wb_clr[wb_Y1_select] = 1'b1;
            if (wb_write[1]) wb_clr[wb_Y2_select] = 1'b1;
        end
    end

`ifdef SCOREBOARD_WB_BYPASS_EN
    assign pending_eff = pending_q & ~wb_clr;
`else
    assign pending_eff = pending_q;
`endif

    // Destination checks guard against WAW reordering against an older in-flight write.
    assign hazard = pending_eff[alu_a_select] | pending_eff[alu_b_select]
                  | pending_eff[alu_c_select] | pending_eff[alu_d_select]
                  | (alu_write[0] & pending_eff[alu_Y1_select])
                  | (alu_write[1] & pending_eff[alu_Y2_select]);

    assign dec_ready  = !hazard && (!issue_valid_q || issue_ready);
    assign accept     = dec_valid && dec_ready;
    assign issue_load = accept && !invalid_instruction;

    always_comb begin
        acc_set = '0;
        if (issue_load) begin
            if (alu_write[0]) acc_set[alu_Y1_select] = 1'b1;
            if (alu_write[1]) acc_set[alu_Y2_select] = 1'b1;
        end
        acc_set[0] = 1'b0;
    end

    // New claims are OR'd after the clear so a same-cycle set wins.
    assign pending_d     = (pending_q & ~wb_clr) | acc_set;
    assign issue_valid_d = issue_load ? 1'b1 : (issue_valid_q && !issue_ready);
    assign illegal_d     = illegal_q | (accept && invalid_instruction);
    assign stall_d       = (dec_valid && hazard && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_valid_q <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            c_q           <= '0;
            d_q           <= '0;
            y1_q          <= '0;
            y2_q          <= '0;
            write_q       <= '0;
            fields_q      <= '0;
            pending_q     <= '0;
            illegal_q     <= 1'b0;
            stall_q       <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            pending_q     <= pending_d;
            illegal_q     <= illegal_d;
            stall_q       <= stall_d;
            if (issue_load) begin
                a_q      <= alu_a_select;
                b_q      <= alu_b_select;
                c_q      <= alu_c_select;
                d_q      <= alu_d_select;
                y1_q     <= alu_Y1_select;
                y2_q     <= alu_Y2_select;
                write_q  <= alu_write;
                fields_q <= fields_in;
            end
        end
    end

    assign issue_valid     = issue_valid_q;
    assign issue_a_select  = a_q;
    assign issue_b_select  = b_q;
    assign issue_c_select  = c_q;
    assign issue_d_select  = d_q;
    assign issue_Y1_select = y1_q;
    assign issue_Y2_select = y2_q;
    assign issue_write     = write_q;
    assign issue_fields    = fields_q;
    assign pending         = pending_q;
    assign illegal_seen    = illegal_q;
    assign stall_count     = stall_q;

endmodule

// File: tb/tb_alu_issue_scoreboard.sv
// Bench for alu_issue_scoreboard: directed vector table, hand sequences, randomized run vs. reference model.
module tb_alu_issue_scoreboard;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dec_valid, dec_ready;
    logic [3:0]  a_sel, b_sel, c_sel, d_sel, y1_sel, y2_sel;
    logic [1:0]  alu_write;
    logic        inv_instr;
    logic [47:0] fields_in;
    logic        issue_valid, issue_ready;
    logic [3:0]  i_a, i_b, i_c, i_d, i_y1, i_y2;
    logic [1:0]  i_write;
    logic [47:0] i_fields;
    logic        wb_valid;
    logic [3:0]  wb_y1, wb_y2;
    logic [1:0]  wb_write;
    logic [15:0] pending;
    logic        illegal_seen;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    alu_issue_scoreboard dut (
        .clk(clk), .reset_n(reset_n),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .alu_a_select(a_sel), .alu_b_select(b_sel), .alu_c_select(c_sel), .alu_d_select(d_sel),
        .alu_Y1_select(y1_sel), .alu_Y2_select(y2_sel), .alu_write(alu_write),
        .invalid_instruction(inv_instr), .fields_in(fields_in),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_a_select(i_a), .issue_b_select(i_b), .issue_c_select(i_c), .issue_d_select(i_d),
        .issue_Y1_select(i_y1), .issue_Y2_select(i_y2), .issue_write(i_write), .issue_fields(i_fields),
        .wb_valid(wb_valid), .wb_Y1_select(wb_y1), .wb_Y2_select(wb_y2), .wb_write(wb_write),
        .pending(pending), .illegal_seen(illegal_seen), .stall_count(stall_count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       dv;
        logic [3:0] a, b, y1, y2;
        logic [1:0] w;
        logic       inv, ir, wbv;
        logic [3:0] wy1, wy2;
        logic [1:0] ww;
        logic       exp_rdy, exp_iv;
        logic [15:0] exp_pend, exp_stall;
        logic       exp_ill;
        logic [3:0] exp_y1;
    } vec_t;

    function automatic vec_t mk(input logic dv, input logic [3:0] a, b, y1, y2, input logic [1:0] w,
                                input logic inv, ir, wbv, input logic [3:0] wy1, wy2, input logic [1:0] ww,
                                input logic rdy, iv, input logic [15:0] pend, stall,
                                input logic ill, input logic [3:0] ey1);
        vec_t v;
        v.dv = dv; v.a = a; v.b = b; v.y1 = y1; v.y2 = y2; v.w = w;
        v.inv = inv; v.ir = ir; v.wbv = wbv; v.wy1 = wy1; v.wy2 = wy2; v.ww = ww;
        v.exp_rdy = rdy; v.exp_iv = iv; v.exp_pend = pend; v.exp_stall = stall;
        v.exp_ill = ill; v.exp_y1 = ey1;
        return v;
    endfunction

    function automatic logic [47:0] fld(input int i);
        logic [7:0] t;
        t = 8'(i);
        return {8'hA5, t, 32'hDEADBEEF};
    endfunction

    task automatic idle_inputs();
        dec_valid = 0; a_sel = 0; b_sel = 0; c_sel = 0; d_sel = 0; y1_sel = 0; y2_sel = 0;
        alu_write = 0; inv_instr = 0; fields_in = 0; issue_ready = 0;
        wb_valid = 0; wb_y1 = 0; wb_y2 = 0; wb_write = 0;
    endtask

    // Reference model state
    bit          m_busy[16];
    bit          m_iv, m_ill;
    int          m_stall;
    logic [3:0]  m_a, m_b, m_c, m_d, m_y1, m_y2;
    logic [1:0]  m_w;
    logic [47:0] m_f;

    task automatic model_reset();
        foreach (m_busy[k]) m_busy[k] = 0;
        m_iv = 0; m_ill = 0; m_stall = 0;
        m_a = 0; m_b = 0; m_c = 0; m_d = 0; m_y1 = 0; m_y2 = 0; m_w = 0; m_f = 0;
    endtask

    vec_t vecs[11];

    initial begin
        logic [15:0] S;
        logic [15:0] pv;
        bit          view[16];
        bit          haz, rdy, acc;
        int          hold_y1;

        S = BYP ? 16'd2 : 16'd3;
        vecs[0]  = mk(1,1,2,3,0,2'b01,0,1,0,0,0,2'b00, 1,1,16'h0008,16'd0,0,3);
        vecs[1]  = mk(1,3,0,4,0,2'b01,0,1,0,0,0,2'b00, 0,0,16'h0008,16'd1,0,3);
        vecs[2]  = mk(1,3,0,4,0,2'b01,0,1,0,0,0,2'b00, 0,0,16'h0008,16'd2,0,3);
        vecs[3]  = mk(1,3,0,4,0,2'b01,0,1,1,3,0,2'b01, BYP,BYP, BYP ? 16'h0010 : 16'h0000, S,0, BYP ? 4'd4 : 4'd3);
        vecs[4]  = mk(1,3,0,5,0,2'b01,0,1,0,0,0,2'b00, 1,1, BYP ? 16'h0030 : 16'h0020, S,0,5);
        vecs[5]  = mk(0,0,0,0,0,2'b00,0,1,1,5,4,2'b11, 1,0,16'h0000,S,0,5);
        vecs[6]  = mk(1,0,0,0,0,2'b01,0,1,0,0,0,2'b00, 1,1,16'h0000,S,0,0);
        vecs[7]  = mk(1,0,0,6,6,2'b11,0,1,0,0,0,2'b00, 1,1,16'h0040,S,0,6);
        vecs[8]  = mk(1,1,0,7,0,2'b01,1,1,0,0,0,2'b00, 1,0,16'h0040,S,1,6);
        vecs[9]  = mk(1,0,0,8,0,2'b01,0,1,1,8,6,2'b11, 1,1,16'h0100,S,1,8);
        vecs[10] = mk(1,0,0,0,0,2'b00,0,0,0,0,0,2'b00, 0,1,16'h0100,S,1,8);

        idle_inputs();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_pending", pending, 0);
        chk("rst_stall", stall_count, 0);
        chk("rst_illegal", illegal_seen, 0);
        chk("rst_issue_regs", {i_a, i_b, i_c, i_d, i_y1, i_y2, i_write, i_fields}, 0);
        reset_n = 1;

        for (int i = 0; i < 11; i++) begin
            dec_valid = vecs[i].dv; a_sel = vecs[i].a; b_sel = vecs[i].b;
            y1_sel = vecs[i].y1; y2_sel = vecs[i].y2; alu_write = vecs[i].w;
            inv_instr = vecs[i].inv; issue_ready = vecs[i].ir; fields_in = fld(i);
            wb_valid = vecs[i].wbv; wb_y1 = vecs[i].wy1; wb_y2 = vecs[i].wy2; wb_write = vecs[i].ww;
            #1;
            chk($sformatf("vec%0d_dec_ready", i), dec_ready, vecs[i].exp_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_issue_valid", i), issue_valid, vecs[i].exp_iv);
            chk($sformatf("vec%0d_pending", i), pending, vecs[i].exp_pend);
            chk($sformatf("vec%0d_stall", i), stall_count, vecs[i].exp_stall);
            chk($sformatf("vec%0d_illegal", i), illegal_seen, vecs[i].exp_ill);
            chk($sformatf("vec%0d_issue_Y1", i), i_y1, vecs[i].exp_y1);
        end

        // Held issue register: new decode offered while issue_ready is low
        idle_inputs();
        dec_valid = 1; a_sel = 9; y1_sel = 10; alu_write = 2'b01; fields_in = 48'h123456789ABC;
        issue_ready = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("hold_dec_ready", dec_ready, 0);
            @(posedge clk);
            #1;
            chk("hold_issue_valid", issue_valid, 1);
            chk("hold_issue_regs", {i_y1, i_write, i_fields}, {4'd8, 2'b01, fld(9)});
            chk("hold_stall", stall_count, S);
        end
        idle_inputs();
        issue_ready = 1;
        @(posedge clk);
        #1;
        chk("release_issue_valid", issue_valid, 0);

        // Reset in the middle of a stall with an issue outstanding
        idle_inputs();
        dec_valid = 1; y1_sel = 9; alu_write = 2'b01; issue_ready = 0;
        @(posedge clk);
        #1;
        chk("pre_rst_pending", pending, 16'h0300);
        a_sel = 8; y1_sel = 0; alu_write = 0;
        #1;
        chk("pre_rst_dec_ready", dec_ready, 0);
        @(posedge clk);
        #1;
        chk("pre_rst_stall", stall_count, S + 16'd1);
        #2;
        reset_n = 0;
        #1;
        chk("midrst_pending", pending, 0);
        chk("midrst_issue_valid", issue_valid, 0);
        chk("midrst_stall", stall_count, 0);
        chk("midrst_illegal", illegal_seen, 0);
        @(posedge clk);
        #1;
        reset_n = 1;
        idle_inputs();
        model_reset();

        // Randomized run against the reference model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            dec_valid   = ($urandom_range(0, 3) != 0);
            a_sel       = 4'($urandom_range(0, 7));
            b_sel       = 4'($urandom_range(0, 7));
            c_sel       = 4'($urandom_range(0, 7));
            d_sel       = 4'($urandom_range(0, 7));
            y1_sel      = 4'($urandom_range(0, 7));
            y2_sel      = ($urandom_range(0, 3) == 0) ? y1_sel : 4'($urandom_range(0, 7));
            alu_write   = 2'($urandom_range(0, 3));
            inv_instr   = ($urandom_range(0, 15) == 0);
            fields_in   = {16'($urandom), 32'($urandom)};
            issue_ready = ($urandom_range(0, 9) < 7);
            wb_valid    = ($urandom_range(0, 1) == 1);
            wb_y1       = 4'($urandom_range(0, 7));
            wb_y2       = 4'($urandom_range(0, 7));
            wb_write    = 2'($urandom_range(0, 3));

            foreach (view[k]) view[k] = m_busy[k];
            if (BYP && wb_valid) begin
                if (wb_write[0]) view[wb_y1] = 0;
                if (wb_write[1]) view[wb_y2] = 0;
            end
            haz = view[a_sel] || view[b_sel] || view[c_sel] || view[d_sel]
               || (alu_write[0] && view[y1_sel]) || (alu_write[1] && view[y2_sel]);
            rdy = !haz && (!m_iv || issue_ready);
            acc = dec_valid && rdy;
            #1;
            chk("rand_dec_ready", dec_ready, rdy);

            if (dec_valid && haz && m_stall < 65535) m_stall++;
            if (wb_valid) begin
                if (wb_write[0]) m_busy[wb_y1] = 0;
                if (wb_write[1]) m_busy[wb_y2] = 0;
            end
            if (acc && inv_instr) m_ill = 1;
            if (acc && !inv_instr) begin
                m_iv = 1;
                m_a = a_sel; m_b = b_sel; m_c = c_sel; m_d = d_sel;
                m_y1 = y1_sel; m_y2 = y2_sel; m_w = alu_write; m_f = fields_in;
                if (alu_write[0] && y1_sel != 0) m_busy[y1_sel] = 1;
                if (alu_write[1] && y2_sel != 0) m_busy[y2_sel] = 1;
            end else if (issue_ready) begin
                m_iv = 0;
            end

            @(posedge clk);
            #1;
            pv = '0;
            foreach (m_busy[k]) pv[k] = m_busy[k];
            hold_y1 = m_y1;
            chk("rand_pending", pending, pv);
            chk("rand_issue_valid", issue_valid, m_iv);
            chk("rand_issue_regs", {i_a, i_b, i_c, i_d, i_y1, i_y2, i_write},
                {m_a, m_b, m_c, m_d, 4'(hold_y1), m_y2, m_w});
            chk("rand_issue_fields", i_fields, m_f);
            chk("rand_illegal", illegal_seen, m_ill);
            chk("rand_stall", stall_count, 16'(m_stall));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_scoreboard.md
ALU_ISSUE_SCOREBOARD -- requirements
Module: alu_issue_scoreboard

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port dec_valid, input, 1 bit: decoder fields below are valid this cycle.
REQ-004 SHALL have port dec_ready, output, 1 bit: block accepts the decoded instruction this cycle.
REQ-005 SHALL have ports alu_a_select, alu_b_select, alu_c_select, alu_d_select, input, 4 bits each: source register indices.
REQ-006 SHALL have ports alu_Y1_select, alu_Y2_select, input, 4 bits each, and alu_write, input, 2 bits: destination indices and per-destination write enables.
REQ-007 SHALL have port invalid_instruction, input, 1 bit: decoder flagged instruction illegal.
REQ-008 SHALL have port fields_in, input, 48 bits: opaque remaining decoder payload, passed through unchanged.
REQ-009 SHALL have port issue_valid, output, 1 bit, and issue_ready, input, 1 bit: issue handshake to ALU datapath.
REQ-010 SHALL have ports issue_a/b/c/d/Y1/Y2_select, output, 4 bits each; issue_write, output, 2 bits; issue_fields, output, 48 bits: registered copies of accepted inputs.
REQ-011 SHALL have ports wb_valid, input, 1 bit; wb_Y1_select, wb_Y2_select, input, 4 bits; wb_write, input, 2 bits: writeback completion.
REQ-012 SHALL have port pending, output, 16 bits: scoreboard, bit n set = register n has outstanding write.
REQ-013 SHALL have ports illegal_seen, output, 1 bit (sticky), and stall_count, output, 16 bits (saturating hazard-stall counter).

Function
REQ-014 SHALL compute hazard = any of a,b,c,d, or Y1 (alu_write[0]) or Y2 (alu_write[1]) hits a set bit in pending_eff.
REQ-015 SHALL define pending_eff as pending, with writeback-cleared bits removed when SCOREBOARD_WB_BYPASS_EN is defined, else pending unchanged.
REQ-016 SHALL drive dec_ready = !hazard && (!issue_valid || issue_ready), combinationally.
REQ-017 SHALL on accept (dec_valid && dec_ready && !invalid_instruction) load all issue_* registers and set issue_valid next cycle; latency 1 cycle.
REQ-018 SHALL on accept of an invalid_instruction drop it (no issue, no scoreboard change) and set illegal_seen.
REQ-019 SHALL clear issue_valid when issue_ready is high and no new accept occurs; hold issue_* stable while issue_valid && !issue_ready.
REQ-020 SHALL on accept set pending[Y1] if alu_write[0] and pending[Y2] if alu_write[1].
REQ-021 SHALL on wb_valid clear pending[wb_Y1_select] if wb_write[0] and pending[wb_Y2_select] if wb_write[1].
REQ-022 SHALL, when set and clear target the same bit in one cycle, leave the bit set.
REQ-023 SHALL never set pending[0]; register 0 is never a hazard source.
REQ-024 SHALL treat Y1 == Y2 with both writes enabled as one pending bit.
REQ-025 SHALL increment stall_count each cycle dec_valid && hazard, saturating at 16'hFFFF.

Reset
REQ-026 SHALL on reset_n low asynchronously clear issue_valid, all issue_* registers, pending, illegal_seen and stall_count to 0.
REQ-027 SHALL discard in-flight issue and scoreboard state on reset mid-operation; no writeback is required afterwards.

Configuration
REQ-028 SHALL honour macro SCOREBOARD_WB_BYPASS_EN: defined -> same-cycle writeback removes hazard and instruction issues that cycle; undefined -> hazard persists until cycle after writeback (one extra stall).

Verification
REQ-029 SHALL test: reset, dec_valid, a=1,b=2, Y1=3, write=01, issue_ready=1 -> issue_valid next cycle, pending=16'h0008.
REQ-030 SHALL test: pending[3] set, decode with a=3 -> dec_ready=0, stall_count increments each cycle until wb Y1=3 write=01.
REQ-031 SHALL test: wb Y1=3 same cycle as dependent decode -> issue same cycle with SCOREBOARD_WB_BYPASS_EN, one cycle later without.
REQ-032 SHALL test: issue_ready=0 with issue_valid=1 -> dec_ready=0, issue_* unchanged for 5 cycles.
REQ-033 SHALL test: invalid_instruction=1 accepted -> illegal_seen=1, issue_valid stays 0, pending unchanged.
REQ-034 SHALL test: Y1=0 write=01 -> pending stays 0; reset_n low mid-stall -> pending=0, issue_valid=0 immediately.
